shot_hit_scheduler: RTL

Sequences hit evaluation for one mouse shot against N on-screen targets with a single shared rectangle comparator. Sits between mouse input decoding and game logic. On an accepted trigger it snapshots the mouse position, scans targets in index order, and reports the lowest-index live target hit. It also tracks remaining ammunition.

---
 rtl/shot_hit_scheduler_pkg.sv | 18 +
 rtl/shot_hit_scheduler_if.sv | 36 +++
 rtl/shot_hit_scheduler_cmp.sv | 39 +++
 rtl/shot_hit_scheduler.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/shot_hit_scheduler_pkg.sv
// Shared constants and types for the shot hit scheduler.
package shot_sched_pkg;

    localparam int unsigned COORD_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        CHECK,
        REPORT
    } state_t;

    // Index width, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shot_hit_scheduler_if.sv
// Handshake/data bundle between the mouse front end and the shot hit scheduler.
interface shot_hit_scheduler_if
    import shot_sched_pkg::*;
#(
    parameter int unsigned N_TARGETS       = 4,
    parameter int unsigned SHOTS_PER_ROUND = 3
) ();

    localparam int unsigned IDX_W  = idx_width(N_TARGETS);
    localparam int unsigned SHOT_W = $clog2(SHOTS_PER_ROUND + 1);

    logic                           trigger;
    logic                           reload;
    logic [COORD_W-1:0]             mouse_x;
    logic [COORD_W-1:0]             mouse_y;
    logic [COORD_W*N_TARGETS-1:0]   target_x_flat;
    logic [COORD_W*N_TARGETS-1:0]   target_y_flat;
    logic [N_TARGETS-1:0]           target_alive;
    logic                           busy;
    logic                           hit_valid;
    logic                           hit;
    logic [IDX_W-1:0]               hit_idx;
    logic [SHOT_W-1:0]              shots_left;
    logic                           empty_click;

    modport master (
        output trigger, reload, mouse_x, mouse_y, target_x_flat, target_y_flat, target_alive,
        input  busy, hit_valid, hit, hit_idx, shots_left, empty_click
    );

    modport slave (
        input  trigger, reload, mouse_x, mouse_y, target_x_flat, target_y_flat, target_alive,
        output busy, hit_valid, hit, hit_idx, shots_left, empty_click
    );

endinterface

// File: rtl/shot_hit_scheduler_cmp.sv
// target_box_cmp: registered point-in-box test, inclusive on all four edges.
// Upper bounds are formed at COORD_W+1 bits so boxes near 1023 never wrap.
module target_box_cmp
    import shot_sched_pkg::*;
#(
    parameter int unsigned TARGET_WIDTH  = 32,
    parameter int unsigned TARGET_HEIGHT = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] i_px,
    input  logic [COORD_W-1:0] i_py,
    input  logic [COORD_W-1:0] i_bx,
    input  logic [COORD_W-1:0] i_by,
    output logic               o_inside
);

    logic [COORD_W:0] w_x_hi;
    logic [COORD_W:0] w_y_hi;
    logic             w_inside;
    logic             r_inside;

    // Combinational box test.
    always_comb begin
        w_x_hi   = {1'b0, i_bx} + (COORD_W+1)'(TARGET_WIDTH);
        w_y_hi   = {1'b0, i_by} + (COORD_W+1)'(TARGET_HEIGHT);
        w_inside = (i_px >= i_bx) && ({1'b0, i_px} <= w_x_hi) &&
                   (i_py >= i_by) && ({1'b0, i_py} <= w_y_hi);
    end

    // Register the result; consumed one cycle later in CHECK.
    always_ff @(posedge clk) begin
        if (rst) r_inside <= 1'b0;
        else     r_inside <= w_inside;
    end

    assign o_inside = r_inside;

endmodule

// File: rtl/shot_hit_scheduler.sv
// shot_hit_scheduler: scans targets in index order with one shared box comparator and
// reports the lowest-index live target under the snapshotted mouse position.
// Optional macro SHOT_QUEUE_EN: latch one trigger arriving while busy and fire it after REPORT.
module shot_hit_scheduler
    import shot_sched_pkg::*;
#(
    parameter int unsigned N_TARGETS       = 4,
    parameter int unsigned TARGET_WIDTH    = 32,
    parameter int unsigned TARGET_HEIGHT   = 24,
    parameter int unsigned SHOTS_PER_ROUND = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    shot_hit_scheduler_if.slave  bus
);

    localparam int unsigned      IDX_W    = idx_width(N_TARGETS);
    localparam int unsigned      SHOT_W   = $clog2(SHOTS_PER_ROUND + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TARGETS - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic                r_hit;
    logic                w_hit_nxt;
    logic [IDX_W-1:0]    r_hit_idx;
    logic [IDX_W-1:0]    w_hit_idx_nxt;
    logic [COORD_W-1:0]  r_mx;
    logic [COORD_W-1:0]  r_my;
    logic [SHOT_W-1:0]   r_shots;
    logic                r_empty;
    logic                w_fire_req;
    logic                w_accept;
    logic                w_inside;
    logic [COORD_W-1:0]  w_tx;
    logic [COORD_W-1:0]  w_ty;

`ifdef SHOT_QUEUE_EN
    logic r_pend;

    // One-deep queue: set by a trigger while busy, consumed on the next IDLE cycle.
    always_ff @(posedge clk) begin
        if (rst)                  r_pend <= 1'b0;
        else if (r_state == IDLE) r_pend <= 1'b0;
        else if (bus.trigger)     r_pend <= 1'b1;
    end

    assign w_fire_req = bus.trigger | r_pend;
`else
    assign w_fire_req = bus.trigger;
`endif

    assign w_accept = (r_state == IDLE) && w_fire_req && (r_shots != '0);

    // Live (not snapshotted) position of the target currently being scanned.
    assign w_tx = bus.target_x_flat[COORD_W*int'(r_idx) +: COORD_W];
    assign w_ty = bus.target_y_flat[COORD_W*int'(r_idx) +: COORD_W];

    target_box_cmp #(
        .TARGET_WIDTH  (TARGET_WIDTH),
        .TARGET_HEIGHT (TARGET_HEIGHT)
    ) u_cmp (
        .clk      (clk),
        .rst      (rst),
        .i_px     (r_mx),
        .i_py     (r_my),
        .i_bx     (w_tx),
        .i_by     (w_ty),
        .o_inside (w_inside)
    );

    // Next-state and scan bookkeeping.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_hit_nxt     = r_hit;
        w_hit_idx_nxt = r_hit_idx;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SCAN;
                    w_idx_nxt   = '0;
                end
            end
            SCAN: w_state_nxt = CHECK;
            CHECK: begin
                if (w_inside && bus.target_alive[r_idx]) begin
                    w_hit_nxt     = 1'b1;
                    w_hit_idx_nxt = r_idx;
                    w_state_nxt   = REPORT;
                end else if (r_idx == LAST_IDX) begin
                    w_hit_nxt     = 1'b0;
                    w_hit_idx_nxt = '0;
                    w_state_nxt   = REPORT;
                end else begin
                    w_idx_nxt   = r_idx + 1'b1;
                    w_state_nxt = SCAN;
                end
            end
            REPORT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, result, snapshot, ammo and empty-click registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_hit     <= 1'b0;
            r_hit_idx <= '0;
            r_mx      <= '0;
            r_my      <= '0;
            r_shots   <= SHOT_W'(SHOTS_PER_ROUND);
            r_empty   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_hit     <= w_hit_nxt;
            r_hit_idx <= w_hit_idx_nxt;
            if (w_accept) begin
                r_mx <= bus.mouse_x;
                r_my <= bus.mouse_y;
            end
            // Reload overrides the decrement of a coincident shot.
            if (bus.reload)    r_shots <= SHOT_W'(SHOTS_PER_ROUND);
            else if (w_accept) r_shots <= r_shots - 1'b1;
            r_empty <= (r_state == IDLE) && w_fire_req && (r_shots == '0);
        end
    end

    assign bus.busy        = (r_state != IDLE);
    assign bus.hit_valid   = (r_state == REPORT);
    assign bus.hit         = r_hit;
    assign bus.hit_idx     = r_hit_idx;
    assign bus.shots_left  = r_shots;
    assign bus.empty_click = r_empty;

endmodule
